manchester_tx: RTL and testbench

MANCHESTER_TX -- requirements
Module: manchester_tx

---
 rtl/manchester_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_manchester_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_tx.sv
// Manchester word transmitter: one-word holding buffer feeding a sync/16-bit/odd-parity shifter.
// Define MKIO_TX_PARITY_INJ_EN to add the inj_parity_err port that inverts a word's parity bit.
module manchester_tx #(
    parameter int HALF_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tx_data,
    input  logic        tx_cd,
    input  logic        tx_ready,
`ifdef MKIO_TX_PARITY_INJ_EN
    input  logic        inj_parity_err,
`endif
    output logic        tx_busy,
    output logic        line_p,
    output logic        line_n,
    output logic        line_active,
    output logic        overrun
);

    localparam int               CNT_W    = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [CNT_W-1:0] clk_cnt_nx_s;
    logic [4:0]       half_idx_r;
    logic [4:0]       half_idx_nx_s;

    logic             ready_q_r;
    logic             rise_s;
    logic             capture_s;
    logic             drop_s;
    logic             inj_s;
    logic             load_s;
    logic             half_end_s;

    logic [15:0]      buf_data_r;
    logic             buf_cd_r;
    logic             buf_inj_r;

    logic [15:0]      sh_data_r;
    logic             sh_cd_r;
    logic             sh_par_r;
    logic [15:0]      sh_data_nx_s;
    logic             sh_cd_nx_s;
    logic             sh_par_nx_s;

    logic             level_s;
    logic             active_s;

    // Parity bit that makes the ones count over data plus parity odd.
    function automatic logic odd_parity(input logic [15:0] d);
        return ~(^d);
    endfunction

`ifdef MKIO_TX_PARITY_INJ_EN
    assign inj_s = inj_parity_err;
`else
    assign inj_s = 1'b0;
`endif

    assign rise_s     = tx_ready & ~ready_q_r;
    assign capture_s  = rise_s & ~tx_busy;
    assign drop_s     = rise_s & tx_busy;
    assign half_end_s = (clk_cnt_r == CNT_LAST);

    // Registered copy of tx_ready; resets high so a level held across reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q_r <= 1'b1;
        end else begin
            ready_q_r <= tx_ready;
        end
    end

    // Holding buffer: tx_busy is its full flag; overrun is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy    <= 1'b0;
            buf_data_r <= 16'h0000;
            buf_cd_r   <= 1'b0;
            buf_inj_r  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (capture_s) begin
                tx_busy    <= 1'b1;
                buf_data_r <= tx_data;
                buf_cd_r   <= tx_cd;
                buf_inj_r  <= inj_s;
            end else if (load_s) begin
                tx_busy    <= 1'b0;
            end
            if (drop_s) begin
                overrun <= 1'b1;
            end
        end
    end

    // State register with half-bit clock counter and half-bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            clk_cnt_r  <= '0;
            half_idx_r <= 5'd0;
        end else begin
            state_r    <= state_nx_s;
            clk_cnt_r  <= clk_cnt_nx_s;
            half_idx_r <= half_idx_nx_s;
        end
    end

    // Next-state logic; a full buffer at the end of parity chains straight into the next sync.
    always_comb begin
        state_nx_s    = state_r;
        clk_cnt_nx_s  = clk_cnt_r;
        half_idx_nx_s = half_idx_r;
        load_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_busy) begin
                    load_s        = 1'b1;
                    state_nx_s    = SYNC;
                    clk_cnt_nx_s  = '0;
                    half_idx_nx_s = 5'd0;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            SYNC, DATA, PARITY: begin
                if (!half_end_s) begin
                    clk_cnt_nx_s = clk_cnt_r + CNT_W'(1);
                end else begin
                    clk_cnt_nx_s = '0;
                    if (state_r == SYNC && half_idx_r == 5'd5) begin
                        state_nx_s    = DATA;
                        half_idx_nx_s = 5'd0;
                    end else if (state_r == DATA && half_idx_r == 5'd31) begin
                        state_nx_s    = PARITY;
                        half_idx_nx_s = 5'd0;
                    end else if (state_r == PARITY && half_idx_r == 5'd1) begin
                        half_idx_nx_s = 5'd0;
                        if (tx_busy) begin
                            load_s     = 1'b1;
                            state_nx_s = SYNC;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        half_idx_nx_s = half_idx_r + 5'd1;
                    end
                end
            end
            default: begin
                state_nx_s    = IDLE;
                clk_cnt_nx_s  = '0;
                half_idx_nx_s = 5'd0;
            end
        endcase
    end

    assign sh_data_nx_s = load_s ? buf_data_r : sh_data_r;
    assign sh_cd_nx_s   = load_s ? buf_cd_r : sh_cd_r;
    assign sh_par_nx_s  = load_s ? (odd_parity(buf_data_r) ^ buf_inj_r) : sh_par_r;

    // Shifter contents for the word currently on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_data_r <= 16'h0000;
            sh_cd_r   <= 1'b0;
            sh_par_r  <= 1'b0;
        end else begin
            sh_data_r <= sh_data_nx_s;
            sh_cd_r   <= sh_cd_nx_s;
            sh_par_r  <= sh_par_nx_s;
        end
    end

    // Line level for the coming cycle, decoded from the next state so outputs are registered.
    always_comb begin
        level_s  = 1'b0;
        active_s = 1'b1;
        case (state_nx_s)
            IDLE: begin
                active_s = 1'b0;
            end
            SYNC: begin
                level_s = (half_idx_nx_s < 5'd3) ? ~sh_cd_nx_s : sh_cd_nx_s;
            end
            DATA: begin
                level_s = sh_data_nx_s[4'd15 - half_idx_nx_s[4:1]] ^ half_idx_nx_s[0];
            end
            PARITY: begin
                level_s = sh_par_nx_s ^ half_idx_nx_s[0];
            end
            default: begin
                active_s = 1'b0;
            end
        endcase
    end

    // Output drivers; both line drives are low while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_active <= 1'b0;
            line_p      <= 1'b0;
            line_n      <= 1'b0;
        end else begin
            line_active <= active_s;
            line_p      <= active_s & level_s;
            line_n      <= active_s & ~level_s;
        end
    end

endmodule

// File: tb/tb_manchester_tx.sv
// Self-checking bench for manchester_tx: expected half-bit levels are queued per issued word
// and compared clock by clock against line_p/line_n while line_active is high.
module tb_manchester_tx;

    localparam int HB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_cd = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_busy;
    logic        line_p;
    logic        line_n;
    logic        line_active;
    logic        overrun;
`ifdef MKIO_TX_PARITY_INJ_EN
    logic        inj_parity_err = 1'b0;
`endif

    int   n_tests = 0;
    int   n_fail = 0;
    logic exp_q[$];
    int   mon_cnt = 0;
    logic mon_lvl = 1'b0;
    int   run_len = 0;
    int   last_run = 0;
    int   runs_done = 0;

    manchester_tx #(.HALF_BIT(HB)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_cd       (tx_cd),
        .tx_ready    (tx_ready),
`ifdef MKIO_TX_PARITY_INJ_EN
        .inj_parity_err(inj_parity_err),
`endif
        .tx_busy     (tx_busy),
        .line_p      (line_p),
        .line_n      (line_n),
        .line_active (line_active),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Queue the 40 half-bit levels a word must produce on the line.
    task automatic push_word(input logic [15:0] d, input logic cd, input bit inj);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back((i < 3) ? ~cd : cd);
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back(d[i]);
            exp_q.push_back(~d[i]);
            if (d[i]) ones++;
        end
        p = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        if (inj) p = ~p;
        exp_q.push_back(p);
        exp_q.push_back(~p);
    endtask

    // Raise tx_ready for three clocks, then drop it for one.
    task automatic issue(input logic [15:0] d, input logic cd, input bit push, input bit inj);
        @(posedge clk); #1;
        tx_data  = d;
        tx_cd    = cd;
        tx_ready = 1'b1;
        if (push) push_word(d, cd, inj);
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_runs(input int target);
        for (int i = 0; i < 6000 && runs_done < target; i++) @(negedge clk);
        #1;
        n_tests++;
        if (runs_done !== target) begin
            n_fail++;
            $display("FAIL word_done_timeout: runs completed %0d, required %0d", runs_done, target);
        end
    endtask

    // Line monitor: pops one expected level per half-bit and checks every clock.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_cnt = 0;
                run_len = 0;
            end else if (line_active) begin
                run_len++;
                if (mon_cnt == 0) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL line_unexpected: line_active=1 at %0t, required no transmission", $time);
                        mon_lvl = line_p;
                    end else begin
                        mon_lvl = exp_q.pop_front();
                    end
                end
                n_tests++;
                if (line_p !== mon_lvl || line_n !== ~mon_lvl) begin
                    n_fail++;
                    $display("FAIL line_level: at %0t p/n=%b%b, required %b%b", $time, line_p, line_n, mon_lvl, ~mon_lvl);
                end
                mon_cnt = (mon_cnt == HB - 1) ? 0 : mon_cnt + 1;
            end else begin
                if (run_len > 0) begin
                    last_run = run_len;
                    runs_done++;
                    run_len = 0;
                end
                n_tests++;
                if ((line_p | line_n) !== 1'b0 || mon_cnt != 0) begin
                    n_fail++;
                    $display("FAIL line_idle: at %0t p/n=%b%b halfbit_clk=%0d, required 00 and 0", $time, line_p, line_n, mon_cnt);
                end
            end
        end
    end

    task automatic test_reset();
        reset    = 1'b1;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_busy, line_p, line_n, line_active, overrun} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000", {tx_busy, line_p, line_n, line_active, overrun});
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_busy, line_active} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy/active=%b, required 00", {tx_busy, line_active});
        end
    endtask

    task automatic test_status_word();
        int r0;
        r0 = runs_done;
        @(posedge clk); #1;
        tx_data  = 16'h0800;
        tx_cd    = 1'b0;
        tx_ready = 1'b1;
        push_word(16'h0800, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL status_busy_pre: got %b, required 0", tx_busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({tx_busy, line_active} !== 2'b10) begin
            n_fail++;
            $display("FAIL status_capture: busy/active=%b, required 10", {tx_busy, line_active});
        end
        @(posedge clk); #1;
        n_tests++;
        if ({tx_busy, line_active, line_p, line_n} !== 4'b0110) begin
            n_fail++;
            $display("FAIL status_load: busy/active/p/n=%b, required 0110", {tx_busy, line_active, line_p, line_n});
        end
        tx_ready = 1'b0;
        wait_runs(r0 + 1);
        n_tests++;
        if (last_run !== 640) begin
            n_fail++;
            $display("FAIL status_length: got %0d clocks, required 640", last_run);
        end
        n_tests++;
        if (exp_q.size() !== 0 || {line_p, line_n, tx_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL status_end: pending=%0d p/n/busy=%b, required 0 and 000", exp_q.size(), {line_p, line_n, tx_busy});
        end
    endtask

    task automatic test_data_word();
        int r0;
        r0 = runs_done;
        issue(16'h0000, 1'b1, 1'b1, 1'b0);
        wait_runs(r0 + 1);
        n_tests++;
        if (last_run !== 640 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL data_word: length %0d pending %0d, required 640 and 0", last_run, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = runs_done;
        issue(16'h0800, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({tx_busy, line_active} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_first_loaded: busy/active=%b, required 01", {tx_busy, line_active});
        end
        issue(16'hFFFF, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_buffered: busy=%b, required 1", tx_busy);
        end
        wait_runs(r0 + 1);
        n_tests++;
        if (last_run !== 1280 || exp_q.size() !== 0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stream: length %0d pending %0d overrun %b, required 1280 0 0", last_run, exp_q.size(), overrun);
        end
    endtask

    task automatic test_overrun();
        int r0;
        r0 = runs_done;
        issue(16'h1234, 1'b0, 1'b1, 1'b0);
        issue(16'hA5C3, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({tx_busy, overrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL overrun_pre: busy/overrun=%b, required 10", {tx_busy, overrun});
        end
        issue(16'hFFFF, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({tx_busy, overrun} !== 2'b11) begin
            n_fail++;
            $display("FAIL overrun_set: busy/overrun=%b, required 11", {tx_busy, overrun});
        end
        wait_runs(r0 + 1);
        n_tests++;
        if (last_run !== 1280 || exp_q.size() !== 0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_stream: length %0d pending %0d overrun %b, required 1280 0 1", last_run, exp_q.size(), overrun);
        end
    endtask

    task automatic test_reset_mid_word();
        int r0;
        int bad;
        r0 = runs_done;
        issue(16'h0800, 1'b0, 1'b1, 1'b0);
        repeat (297) @(negedge clk);
        #2;
        reset    = 1'b1;
        tx_ready = 1'b1;
        #1;
        n_tests++;
        if ({tx_busy, line_p, line_n, line_active, overrun} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midword_reset: got %b, required 00000", {tx_busy, line_p, line_n, line_active, overrun});
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (line_active !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        tx_ready = 1'b0;
        n_tests++;
        if (bad !== 0 || runs_done !== r0) begin
            n_fail++;
            $display("FAIL held_ready_after_reset: active clocks %0d runs %0d, required 0 and %0d", bad, runs_done, r0);
        end
    endtask

`ifdef MKIO_TX_PARITY_INJ_EN
    task automatic test_parity_inject();
        int r0;
        r0 = runs_done;
        inj_parity_err = 1'b1;
        issue(16'h0000, 1'b1, 1'b1, 1'b1);
        inj_parity_err = 1'b0;
        wait_runs(r0 + 1);
        n_tests++;
        if (last_run !== 640 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL parity_inject: length %0d pending %0d, required 640 and 0", last_run, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_status_word();
        test_data_word();
        test_back_to_back();
        test_overrun();
        test_reset_mid_word();
`ifdef MKIO_TX_PARITY_INJ_EN
        test_parity_inject();
`endif
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
